mem_responder: RTL and testbench

Word-organised memory target that serves load/store requests from the multicycle processor's control/datapath over a valid/ready request channel and a valid/ready response channel. It is the responder end of the processor's memory-access protocol. It models a fixed, parameterised access latency so that the control unit's wait states are exercised. One request is in flight at a time; there is no pipelining.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_word_array.sv | 29 ++
 rtl/mem_responder.sv | 112 +++++++++++
 tb/tb_mem_responder.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the word-organised memory responder.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam int BYTE_LANES = 4;

  // Misaligned or beyond the DEPTH-word window.
  function automatic logic is_err(input logic [31:0] addr, input int addr_w);
    logic hi;
    hi = 1'b0;
    for (int i = 2; i < 32; i++) begin
      if ((i >= addr_w + 2) && addr[i]) hi = 1'b1;
    end
    return (addr[1:0] != 2'b00) || hi;
  endfunction

  function automatic logic [31:0] be_to_mask(input logic [BYTE_LANES-1:0] be);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < BYTE_LANES; i++) mask[8*i +: 8] = {8{be[i]}};
    return mask;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response channel between the processor and the memory responder.
interface mem_responder_if;
  import mem_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic [BYTE_LANES-1:0] req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_word_array.sv
// DEPTH x DATA_W storage: bit-masked synchronous write, combinational read, sync clear.
module mem_word_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] wmask_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[addr_i] <= (mem_q[addr_i] & ~wmask_i) | (wdata_i & wmask_i);
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store target with a fixed LATENCY-cycle wait before commit.
// Response is held in RESP until accepted; no new request is taken until then.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input logic            CLK,
  input logic            RST,
  mem_responder_if.slave bus
);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [31:0]           addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [BYTE_LANES-1:0] be_q, be_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_rdata;

  mem_word_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk_i   (CLK),
    .rst_i   (RST),
    .we_i    (mem_we),
    .addr_i  (addr_q[ADDR_W+1:2]),
    .wdata_i (wdata_q),
    .wmask_i (be_to_mask(be_q)),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Commit: errors and stores both return zero data.
          err_d   = is_err(addr_q, ADDR_W);
          rdata_d = '0;
          if (!err_d) begin
            if (we_q) mem_we  = 1'b1;
            else      rdata_d = mem_rdata;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE) && !RST;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances at LATENCY 2, 1 and 15.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rv, rr;
  logic        we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [2:0]  rdy_w, vld_w, err_w;
  logic [31:0] rdata_w [3];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    mem_responder_if bus ();
    assign bus.req_valid = rv[g];
    assign bus.req_we    = we;
    assign bus.req_addr  = addr;
    assign bus.req_wdata = wdata;
    assign bus.req_be    = be;
    assign bus.rsp_ready = rr[g];
    assign rdy_w[g]      = bus.req_ready;
    assign vld_w[g]      = bus.rsp_valid;
    assign rdata_w[g]    = bus.rsp_rdata;
    assign err_w[g]      = bus.rsp_err;
    mem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(LAT)) u_dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 15;
  endfunction

  // Drive one request on instance d; gap counts edges from the accept edge to first rsp_valid.
  task automatic do_txn(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b, input bit ack,
                        output logic [31:0] rd, output logic er, output int gap);
    int n;
    @(negedge clk);
    we = w; addr = a; wdata = wd; be = b; rv[d] = 1'b1;
    n = 0;
    while (!rdy_w[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    gap = 0; rd = '0; er = 1'b0;
    if (rdy_w[d]) begin
      @(posedge clk);
      gap = 1;
      @(negedge clk);
      rv[d] = 1'b0;
      while (!vld_w[d] && gap < 40) begin
        @(posedge clk);
        gap++;
        @(negedge clk);
      end
      rd = rdata_w[d];
      er = err_w[d];
      if (ack && vld_w[d]) begin
        rr[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rr[d] = 1'b0;
      end
    end else begin
      rv[d] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (rdy_w !== 3'b000 || vld_w !== 3'b000 || err_w !== 3'b000 || rdata_w[0] !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: rdy=%b vld=%b err=%b rdata=%h, want 000 000 000 0", rdy_w, vld_w, err_w, rdata_w[0]);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (rdy_w !== 3'b111) begin
      fails++;
      $display("FAIL reset_release_ready: rdy=%b want 111", rdy_w);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int gap;
    do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, rd, er, gap);
    tests++;
    if (gap !== 3 || er !== 1'b0 || rd !== 32'h0) begin
      fails++;
      $display("FAIL store_rsp: gap=%0d err=%b rdata=%h, want 3 0 00000000", gap, er, rd);
    end
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, er, gap);
    tests++;
    if (gap !== 3 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL load_after_store: gap=%0d err=%b rdata=%h, want 3 0 deadbeef", gap, er, rd);
    end
  endtask

  task automatic test_partial();
    logic [31:0] rd; logic er; int gap;
    do_txn(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 1'b1, rd, er, gap);
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, er, gap);
    tests++;
    if (rd !== 32'hDEADBEAA || er !== 1'b0) begin
      fails++;
      $display("FAIL partial_be0001: rdata=%h err=%b, want deadbeaa 0", rd, er);
    end
    do_txn(0, 1'b1, 32'h10, 32'h11111111, 4'b0000, 1'b1, rd, er, gap);
    tests++;
    if (gap !== 3 || er !== 1'b0 || rd !== 32'h0) begin
      fails++;
      $display("FAIL be0000_rsp: gap=%0d err=%b rdata=%h, want 3 0 00000000", gap, er, rd);
    end
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, er, gap);
    tests++;
    if (rd !== 32'hDEADBEAA) begin
      fails++;
      $display("FAIL be0000_unchanged: rdata=%h want deadbeaa", rd);
    end
    do_txn(0, 1'b1, 32'h10, 32'hCAFE0000, 4'b1100, 1'b1, rd, er, gap);
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, er, gap);
    tests++;
    if (rd !== 32'hCAFEBEAA) begin
      fails++;
      $display("FAIL partial_be1100: rdata=%h want cafebeaa", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int gap;
    do_txn(0, 1'b0, 32'h11, 32'h0, 4'h0, 1'b1, rd, er, gap);
    tests++;
    if (er !== 1'b1 || rd !== 32'h0 || gap !== 3) begin
      fails++;
      $display("FAIL err_misaligned: err=%b rdata=%h gap=%0d, want 1 00000000 3", er, rd, gap);
    end
    do_txn(0, 1'b0, 32'h400, 32'h0, 4'h0, 1'b1, rd, er, gap);
    tests++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      fails++;
      $display("FAIL err_range: err=%b rdata=%h, want 1 00000000", er, rd);
    end
    do_txn(0, 1'b1, 32'h0, 32'h12345678, 4'hF, 1'b1, rd, er, gap);
    do_txn(0, 1'b1, 32'h402, 32'hFFFFFFFF, 4'hF, 1'b1, rd, er, gap);
    tests++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      fails++;
      $display("FAIL err_store: err=%b rdata=%h, want 1 00000000", er, rd);
    end
    do_txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, rd, er, gap);
    tests++;
    if (er !== 1'b0 || rd !== 32'h12345678) begin
      fails++;
      $display("FAIL err_store_no_write: err=%b rdata=%h, want 0 12345678", er, rd);
    end
    do_txn(0, 1'b1, 32'h3FC, 32'h0BADF00D, 4'hF, 1'b1, rd, er, gap);
    do_txn(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 1'b1, rd, er, gap);
    tests++;
    if (er !== 1'b0 || rd !== 32'h0BADF00D) begin
      fails++;
      $display("FAIL last_word: err=%b rdata=%h, want 0 0badf00d", er, rd);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int gap; bit ok;
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, gap);
    tests++;
    if (rd !== 32'hCAFEBEAA || gap !== 3) begin
      fails++;
      $display("FAIL bp_first: rdata=%h gap=%0d, want cafebeaa 3", rd, gap);
    end
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      we = 1'b1; addr = 32'h10; wdata = 32'h0; be = 4'hF;
      rv[0] = (i < 2);
      if (vld_w[0] !== 1'b1 || rdata_w[0] !== 32'hCAFEBEAA || err_w[0] !== 1'b0 || rdy_w[0] !== 1'b0)
        ok = 1'b0;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL bp_hold: vld=%b rdata=%h err=%b rdy=%b, want 1 cafebeaa 0 0", vld_w[0], rdata_w[0], err_w[0], rdy_w[0]);
    end
    @(negedge clk);
    rv[0] = 1'b0; rr[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rr[0] = 1'b0;
    tests++;
    if (vld_w[0] !== 1'b0 || rdata_w[0] !== 32'h0 || err_w[0] !== 1'b0 || rdy_w[0] !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: vld=%b rdata=%h err=%b rdy=%b, want 0 0 0 1", vld_w[0], rdata_w[0], err_w[0], rdy_w[0]);
    end
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (vld_w[0] !== 1'b0) ok = 1'b0;
    end
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, er, gap);
    tests++;
    if (!ok || rd !== 32'hCAFEBEAA) begin
      fails++;
      $display("FAIL bp_pulse_ignored: quiet=%b rdata=%h, want 1 cafebeaa", ok, rd);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic er; int gap; bit quiet;
    @(negedge clk);
    we = 1'b1; addr = 32'h20; wdata = 32'h55555555; be = 4'hF; rv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rv[0] = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (rdy_w[0] !== 1'b1 || vld_w[0] !== 1'b0) begin
      fails++;
      $display("FAIL rst_wait_idle: rdy=%b vld=%b, want 1 0", rdy_w[0], vld_w[0]);
    end
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (vld_w[0] !== 1'b0) quiet = 1'b0;
    end
    tests++;
    if (!quiet) begin
      fails++;
      $display("FAIL rst_wait_no_rsp: rsp_valid rose=1, want 0");
    end
    do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, rd, er, gap);
    tests++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      fails++;
      $display("FAIL rst_wait_abandon: rdata=%h err=%b, want 00000000 0", rd, er);
    end
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, er, gap);
    tests++;
    if (rd !== 32'h0) begin
      fails++;
      $display("FAIL rst_clears_mem: rdata=%h want 00000000", rd);
    end
  endtask

  task automatic test_latency_sweep(input int d);
    logic [31:0] rd; logic er; int gap;
    do_txn(d, 1'b1, 32'h8, 32'hA5A50F0F, 4'hF, 1'b1, rd, er, gap);
    tests++;
    if (gap !== lat_of(d) + 1 || rd !== 32'h0) begin
      fails++;
      $display("FAIL sweep_store_L%0d: gap=%0d rdata=%h, want %0d 00000000", lat_of(d), gap, rd, lat_of(d) + 1);
    end
    do_txn(d, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1, rd, er, gap);
    tests++;
    if (gap !== lat_of(d) + 1 || rd !== 32'hA5A50F0F || er !== 1'b0) begin
      fails++;
      $display("FAIL sweep_load_L%0d: gap=%0d rdata=%h err=%b, want %0d a5a50f0f 0", lat_of(d), gap, rd, er, lat_of(d) + 1);
    end
  endtask

  task automatic test_back_to_back(input int d);
    int acc[$];
    int lat;
    lat = lat_of(d);
    @(negedge clk);
    we = 1'b0; addr = 32'h8; wdata = 32'h0; be = 4'h0;
    rr[d] = 1'b1; rv[d] = 1'b1;
    for (int cyc = 0; cyc < 3 * (lat + 2) + 2; cyc++) begin
      if (rv[d] && rdy_w[d]) acc.push_back(cyc);
      @(negedge clk);
    end
    rv[d] = 1'b0;
    repeat (lat + 3) @(negedge clk);
    rr[d] = 1'b0;
    tests++;
    if (acc.size() < 3) begin
      fails++;
      $display("FAIL b2b_L%0d_count: accepts=%0d want >=3", lat, acc.size());
    end else if (acc[1] - acc[0] !== lat + 2 || acc[2] - acc[1] !== lat + 2) begin
      fails++;
      $display("FAIL b2b_L%0d_spacing: got %0d,%0d want %0d", lat, acc[1] - acc[0], acc[2] - acc[1], lat + 2);
    end
  endtask

  initial begin
    rv = '0; rr = '0; we = 1'b0; addr = '0; wdata = '0; be = '0; rst = 1'b1;
    test_reset();
    test_store_load();
    test_partial();
    test_errors();
    test_backpressure();
    test_reset_mid_wait();
    test_latency_sweep(1);
    test_latency_sweep(2);
    test_back_to_back(0);
    test_back_to_back(1);
    test_back_to_back(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
